// File: rtl/spi_byte_master.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One start pulse frames exactly one byte: cs_n drops, eight bits go out on
// mosi while eight bits are captured from miso, cs_n rises and done pulses
// for one cycle with the received byte on data_out. Longer commands are built
// by the caller as a chain of single-byte transactions.

module spi_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       done,
  output logic [7:0] data_out,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  // Divider width: enough bits to hold CLK_DIV-1 (CLK_DIV is at least 2).
  localparam int              DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] divider;
  logic [3:0]       toggle_cnt;
  // Bit 7 of the outgoing byte is loaded straight into mosi, so only the
  // remaining seven bits need to be kept for later falling edges.
  logic [6:0]       tx_shift;
  logic [7:0]       rx_shift;

  // Frame sequencer: every output is driven from this one register block so
  // sclk, mosi, cs_n and done are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      divider    <= '0;
      toggle_cnt <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      done       <= 1'b0;
      data_out   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= data_in[6:0];
            mosi     <= data_in[7];
            cs_n     <= 1'b0;
            divider  <= '0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (divider == DIV_LAST) begin
            divider    <= '0;
            toggle_cnt <= '0;
            state      <= XFER;
          end else begin
            divider <= divider + 1'b1;
          end
        end

        XFER: begin
          if (divider == DIV_LAST) begin
            divider    <= '0;
            sclk       <= ~sclk;
            toggle_cnt <= toggle_cnt + 4'd1;
            if (!sclk) begin
              rx_shift <= {rx_shift[6:0], miso};
            end else if (toggle_cnt != 4'd15) begin
              mosi     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end
            if (toggle_cnt == 4'd15) begin
              state <= HOLD;
            end
          end else begin
            divider <= divider + 1'b1;
          end
        end

        HOLD: begin
          if (divider == DIV_LAST) begin
            divider <= '0;
            state   <= DONE;
          end else begin
            divider <= divider + 1'b1;
          end
        end

        DONE: begin
          cs_n     <= 1'b1;
          mosi     <= 1'b0;
          done     <= 1'b1;
          data_out <= rx_shift;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master (CLK_DIV=4).
// A small SPI slave drives miso from a chosen byte (or loops mosi back), a
// monitor collects mosi on every rising sclk, and each scenario task compares
// what it saw with what a byte-level model of the protocol predicts.

module tb_spi_byte_master;

  localparam int CLK_DIV   = 4;
  localparam int LATENCY   = 18 * CLK_DIV + 1;
  localparam int MAX_WAIT  = 400;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic       done;
  logic [7:0] data_out;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  int passed;
  int total;

  logic       loopback;
  logic [7:0] slave_byte;
  logic       slave_bit;
  int         slave_idx;
  logic [7:0] last_rx;

  bit         mosi_q[$];
  int         rise_count;

  int         obs_latency;
  int         obs_bad;
  int         obs_rises;
  logic [7:0] obs_mosi_byte;
  logic [7:0] obs_rx;
  logic       obs_cs_done;
  logic       obs_mosi_done;

  spi_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .done     (done),
    .data_out (data_out),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso = loopback ? mosi : slave_bit;

  // Slave presents its MSB when selected and the next bit on each falling sclk.
  always @(negedge cs_n) begin
    slave_bit = slave_byte[7];
    slave_idx = 6;
  end

  always @(negedge sclk) begin
    if (!cs_n && slave_idx >= 0) begin
      slave_bit = slave_byte[slave_idx];
      slave_idx = slave_idx - 1;
    end
  end

  // Record what the master drives at each rising sclk.
  always @(posedge sclk) begin
    mosi_q.push_back(mosi);
    rise_count = rise_count + 1;
  end

  // Drives one frame from the current time (#1 after a clock edge) and
  // collects observations; the scenario tasks do the comparing.
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] sb, input bit inject);
    bit seen;
    int n;
    slave_byte = sb;
    mosi_q.delete();
    rise_count = 0;
    start   = 1'b1;
    data_in = tx;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = 8'($urandom);
    n = 0;
    seen = 0;
    obs_bad = 0;
    while (!seen && n < MAX_WAIT) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        if (cs_n !== 1'b0) obs_bad++;
        if (data_out !== last_rx) obs_bad++;
      end
      if (inject && n == 20) begin
        start   = 1'b1;
        data_in = 8'hFF;
      end
      if (inject && n == 21) start = 1'b0;
    end
    obs_latency   = seen ? n : -1;
    obs_rises     = rise_count;
    obs_mosi_byte = 8'h00;
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) obs_mosi_byte[7-i] = mosi_q[i];
    obs_rx        = data_out;
    obs_cs_done   = cs_n;
    obs_mosi_done = mosi;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    start = 1'b1;
    data_in = 8'hA5;
    #1;
    total++;
    if ({sclk, mosi, cs_n, done, data_out} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00})
      $display("[TB] FAIL reset_values: got sclk=%b mosi=%b cs_n=%b done=%b data_out=%h, want 0 0 1 0 00",
               sclk, mosi, cs_n, done, data_out);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cs_n !== 1'b1 || sclk !== 1'b0)
      $display("[TB] FAIL reset_start_ignored: got cs_n=%b sclk=%b, want 1 0", cs_n, sclk);
    else passed++;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cs_n !== 1'b1 || done !== 1'b0 || data_out !== 8'h00)
      $display("[TB] FAIL idle_after_reset: got cs_n=%b done=%b data_out=%h, want 1 0 00", cs_n, done, data_out);
    else passed++;
    last_rx = 8'h00;
  endtask

  task automatic test_loopback();
    loopback = 1'b1;
    run_frame(8'hA5, 8'h00, 0);
    total++;
    if (obs_latency != LATENCY)
      $display("[TB] FAIL loop_latency: got %0d, want %0d", obs_latency, LATENCY);
    else passed++;
    total++;
    if (obs_mosi_byte !== 8'hA5 || obs_rises != 8)
      $display("[TB] FAIL loop_mosi: got %h (%0d rises), want a5 (8 rises)", obs_mosi_byte, obs_rises);
    else passed++;
    total++;
    if (obs_rx !== 8'hA5)
      $display("[TB] FAIL loop_data_out: got %h, want a5", obs_rx);
    else passed++;
    total++;
    if (obs_bad != 0 || obs_cs_done !== 1'b1 || obs_mosi_done !== 1'b0)
      $display("[TB] FAIL loop_framing: got bad=%0d cs_n=%b mosi=%b at done, want 0 1 0",
               obs_bad, obs_cs_done, obs_mosi_done);
    else passed++;
    last_rx = 8'hA5;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0)
      $display("[TB] FAIL loop_done_width: got done=%b one cycle later, want 0", done);
    else passed++;
    loopback = 1'b0;
  endtask

  task automatic test_tied_miso();
    logic [7:0] tied [2];
    tied[0] = 8'hFF;
    tied[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      run_frame(8'h3C, tied[k], 0);
      total++;
      if (obs_rx !== tied[k] || obs_latency != LATENCY)
        $display("[TB] FAIL tied_miso_%0d: got data_out=%h latency=%0d, want %h %0d",
                 k, obs_rx, obs_latency, tied[k], LATENCY);
      else passed++;
      total++;
      if (obs_mosi_byte !== 8'h3C || obs_bad != 0)
        $display("[TB] FAIL tied_mosi_%0d: got %h bad=%0d, want 3c 0", k, obs_mosi_byte, obs_bad);
      else passed++;
      last_rx = tied[k];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [7:0] tx;
    logic [7:0] sb;
    for (int k = 0; k < 6; k++) begin
      tx = 8'($urandom);
      sb = 8'($urandom);
      run_frame(tx, sb, 0);
      total++;
      if (obs_mosi_byte !== tx || obs_rx !== sb || obs_latency != LATENCY || obs_bad != 0)
        $display("[TB] FAIL random_%0d: got mosi=%h rx=%h lat=%0d bad=%0d, want %h %h %0d 0",
                 k, obs_mosi_byte, obs_rx, obs_latency, obs_bad, tx, sb, LATENCY);
      else passed++;
      last_rx = sb;
      repeat (1 + $urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5];
    logic [7:0] sb;
    seq[0] = 8'h01; seq[1] = 8'h10; seq[2] = 8'h00; seq[3] = 8'h00; seq[4] = 8'h00;
    for (int k = 0; k < 5; k++) begin
      sb = 8'($urandom);
      run_frame(seq[k], sb, 0);
      total++;
      if (obs_mosi_byte !== seq[k] || obs_rx !== sb || obs_latency != LATENCY ||
          obs_bad != 0 || obs_cs_done !== 1'b1)
        $display("[TB] FAIL b2b_%0d: got mosi=%h rx=%h lat=%0d bad=%0d cs_n=%b, want %h %h %0d 0 1",
                 k, obs_mosi_byte, obs_rx, obs_latency, obs_bad, obs_cs_done, seq[k], sb, LATENCY);
      else passed++;
      last_rx = sb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_while_busy();
    run_frame(8'h96, 8'h5A, 1);
    total++;
    if (obs_mosi_byte !== 8'h96 || obs_rx !== 8'h5A || obs_latency != LATENCY)
      $display("[TB] FAIL busy_start: got mosi=%h rx=%h lat=%0d, want 96 5a %0d",
               obs_mosi_byte, obs_rx, obs_latency, LATENCY);
    else passed++;
    last_rx = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (cs_n !== 1'b1 || done !== 1'b0)
      $display("[TB] FAIL busy_no_extra_frame: got cs_n=%b done=%b, want 1 0", cs_n, done);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int done_seen;
    slave_byte = 8'hC3;
    rise_count = 0;
    start = 1'b1;
    data_in = 8'h81;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (rise_count < 4 && n < MAX_WAIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (rise_count != 4)
      $display("[TB] FAIL midreset_reach: got %0d rises, want 4", rise_count);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({sclk, mosi, cs_n, done, data_out} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00})
      $display("[TB] FAIL midreset_values: got sclk=%b mosi=%b cs_n=%b done=%b data_out=%h, want 0 0 1 0 00",
               sclk, mosi, cs_n, done, data_out);
    else passed++;
    last_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || cs_n !== 1'b1) done_seen++;
    end
    total++;
    if (done_seen != 0)
      $display("[TB] FAIL midreset_no_done: got %0d active cycles, want 0", done_seen);
    else passed++;
    run_frame(8'h6E, 8'h27, 0);
    total++;
    if (obs_mosi_byte !== 8'h6E || obs_rx !== 8'h27 || obs_latency != LATENCY || obs_rises != 8)
      $display("[TB] FAIL midreset_clean_frame: got mosi=%h rx=%h lat=%0d rises=%0d, want 6e 27 %0d 8",
               obs_mosi_byte, obs_rx, obs_latency, obs_rises, LATENCY);
    else passed++;
    last_rx = 8'h27;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    start      = 1'b0;
    data_in    = 8'h00;
    loopback   = 1'b0;
    slave_byte = 8'h00;
    slave_bit  = 1'b0;
    slave_idx  = -1;
    rise_count = 0;
    last_rx    = 8'h00;
    test_reset();
    test_loopback();
    test_tied_miso();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
